// File: rtl/tone_band_classifier.sv
// -----------------------------------------------------------------------------
// tone_band_classifier
//
// Measures the period of a comparator-squared audio tone and reports which of
// five frequency bands it has been stable in. The tone is synchronised, its
// rising edges are turned into 1-cycle pulses, and the clk-cycle count between
// pulses is classified against five inclusive period windows. A band is
// declared locked after MATCH_COUNT consecutive periods fall in it. The lock is
// dropped on the first off-band period or after TIMEOUT cycles with no edge.
//
// Ports
//   clk        in   system clock, all logic on the rising edge
//   rst        in   synchronous, active-high reset
//   toneIn     in   asynchronous squared audio
//   bp1..bp5   out  one-hot locked-band indicators (registered)
//   bandValid  out  high whenever one of bp1..bp5 is high (registered)
//
// Build option
//   TONE_GLITCH_FILTER_EN  when defined, the synchronised level only changes
//                          after 4 consecutive identical samples, which adds
//                          4 cycles of edge latency but leaves the measured
//                          period unchanged.
// -----------------------------------------------------------------------------
module tone_band_classifier #(
    parameter int unsigned BAND1_LO    = 47_500,
    parameter int unsigned BAND1_HI    = 52_500,
    parameter int unsigned BAND2_LO    = 31_667,
    parameter int unsigned BAND2_HI    = 35_000,
    parameter int unsigned BAND3_LO    = 23_750,
    parameter int unsigned BAND3_HI    = 26_250,
    parameter int unsigned BAND4_LO    = 19_000,
    parameter int unsigned BAND4_HI    = 21_000,
    parameter int unsigned BAND5_LO    = 15_834,
    parameter int unsigned BAND5_HI    = 17_500,
    parameter int unsigned MATCH_COUNT = 8,
    parameter int unsigned TIMEOUT     = 100_000
) (
    input  logic clk,
    input  logic rst,
    input  logic toneIn,
    output logic bp1,
    output logic bp2,
    output logic bp3,
    output logic bp4,
    output logic bp5,
    output logic bandValid
);

    localparam int CNT_W = 17;
    localparam logic [CNT_W-1:0] CNT_ZERO  = 17'd0;
    localparam logic [CNT_W-1:0] CNT_ONE   = 17'd1;
    localparam logic [CNT_W-1:0] CNT_MAX   = 17'd131_071;
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    localparam logic [CNT_W-1:0] B1_LO = CNT_W'(BAND1_LO);
    localparam logic [CNT_W-1:0] B1_HI = CNT_W'(BAND1_HI);
    localparam logic [CNT_W-1:0] B2_LO = CNT_W'(BAND2_LO);
    localparam logic [CNT_W-1:0] B2_HI = CNT_W'(BAND2_HI);
    localparam logic [CNT_W-1:0] B3_LO = CNT_W'(BAND3_LO);
    localparam logic [CNT_W-1:0] B3_HI = CNT_W'(BAND3_HI);
    localparam logic [CNT_W-1:0] B4_LO = CNT_W'(BAND4_LO);
    localparam logic [CNT_W-1:0] B4_HI = CNT_W'(BAND4_HI);
    localparam logic [CNT_W-1:0] B5_LO = CNT_W'(BAND5_LO);
    localparam logic [CNT_W-1:0] B5_HI = CNT_W'(BAND5_HI);

    localparam int MC_W = $clog2(MATCH_COUNT + 1);
    localparam logic [MC_W-1:0] MC_ZERO   = {MC_W{1'b0}};
    localparam logic [MC_W-1:0] MC_ONE    = {{(MC_W-1){1'b0}}, 1'b1};
    localparam logic [MC_W-1:0] MC_TARGET = MC_W'(MATCH_COUNT);

    // Band code 0 means "no band"; 1..5 name the windows.
    localparam logic [2:0] BAND_NONE = 3'd0;

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        MEASURE = 2'b01,
        LOCKED  = 2'b10
    } state_t;

    // Windows are tested in ascending index order so overlaps resolve to the
    // lowest band.
    function automatic logic [2:0] classify_period(input logic [CNT_W-1:0] period);
        logic [2:0] band;
        if ((period >= B1_LO) && (period <= B1_HI)) begin
            band = 3'd1;
        end else if ((period >= B2_LO) && (period <= B2_HI)) begin
            band = 3'd2;
        end else if ((period >= B3_LO) && (period <= B3_HI)) begin
            band = 3'd3;
        end else if ((period >= B4_LO) && (period <= B4_HI)) begin
            band = 3'd4;
        end else if ((period >= B5_LO) && (period <= B5_HI)) begin
            band = 3'd5;
        end else begin
            band = BAND_NONE;
        end
        return band;
    endfunction

    function automatic logic [4:0] band_to_onehot(input logic [2:0] band);
        logic [4:0] onehot;
        case (band)
            3'd1:    onehot = 5'b00001;
            3'd2:    onehot = 5'b00010;
            3'd3:    onehot = 5'b00100;
            3'd4:    onehot = 5'b01000;
            3'd5:    onehot = 5'b10000;
            default: onehot = 5'b00000;
        endcase
        return onehot;
    endfunction

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level_d;
    logic             w_level;
    logic             w_edge;
    logic [CNT_W-1:0] r_cnt;
    logic             w_timeout;
    logic [2:0]       w_period_band;
    state_t           r_state;
    state_t           w_state_n;
    logic [2:0]       r_band;
    logic [2:0]       w_band_n;
    logic [MC_W-1:0]  r_match;
    logic [MC_W-1:0]  w_match_n;
    logic [4:0]       r_bp;
    logic [4:0]       w_bp_n;
    logic             r_valid;

    // Two-flop synchroniser for the asynchronous tone input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= toneIn;
            r_sync2 <= r_sync1;
        end
    end

`ifdef TONE_GLITCH_FILTER_EN
    logic [2:0] r_hist;
    logic       r_filt;

    // Majority-free debounce: the level follows only after the current sample
    // and the three before it all agree, so short glitches never reach the
    // edge detector and every edge is delayed by the same 4 cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= 3'b000;
            r_filt <= 1'b0;
        end else begin
            r_hist <= {r_hist[1:0], r_sync2};
            if ({r_hist, r_sync2} == 4'b1111) begin
                r_filt <= 1'b1;
            end else if ({r_hist, r_sync2} == 4'b0000) begin
                r_filt <= 1'b0;
            end else begin
                r_filt <= r_filt;
            end
        end
    end

    assign w_level = r_filt;
`else
    assign w_level = r_sync2;
`endif

    // Delayed copy of the level for rising-edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_level_d <= 1'b0;
        end else begin
            r_level_d <= w_level;
        end
    end

    assign w_edge = w_level & ~r_level_d;

    // The counter restarts at 1 on an edge so that its value at the next edge
    // equals the number of cycles between the two pulses.
    assign w_timeout     = (r_state != IDLE) && (r_cnt == TIMEOUT_C);
    assign w_period_band = classify_period(r_cnt);

    // Saturating period counter; parked at zero while idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= CNT_ZERO;
        end else if (w_edge) begin
            r_cnt <= CNT_ONE;
        end else if ((r_state == IDLE) || w_timeout) begin
            r_cnt <= CNT_ZERO;
        end else if (r_cnt != CNT_MAX) begin
            r_cnt <= r_cnt + CNT_ONE;
        end else begin
            r_cnt <= r_cnt;
        end
    end

    // Next-state, match tracking and next output decode. An edge is examined
    // before the timeout so a period of exactly TIMEOUT is still classified.
    always_comb begin
        w_state_n = r_state;
        w_band_n  = r_band;
        w_match_n = r_match;
        w_bp_n    = r_bp;
        case (r_state)
            IDLE: begin
                w_bp_n    = 5'b00000;
                w_match_n = MC_ZERO;
                w_band_n  = BAND_NONE;
                if (w_edge) begin
                    w_state_n = MEASURE;
                end else begin
                    w_state_n = IDLE;
                end
            end
            MEASURE: begin
                if (w_edge) begin
                    if (w_period_band == BAND_NONE) begin
                        w_match_n = MC_ZERO;
                        w_band_n  = BAND_NONE;
                    end else if (w_period_band == r_band) begin
                        w_match_n = r_match + MC_ONE;
                    end else begin
                        w_match_n = MC_ONE;
                        w_band_n  = w_period_band;
                    end
                    if (w_match_n == MC_TARGET) begin
                        w_state_n = LOCKED;
                        w_bp_n    = band_to_onehot(w_band_n);
                    end else begin
                        w_bp_n    = 5'b00000;
                    end
                end else if (w_timeout) begin
                    w_state_n = IDLE;
                    w_match_n = MC_ZERO;
                    w_band_n  = BAND_NONE;
                    w_bp_n    = 5'b00000;
                end else begin
                    w_bp_n    = 5'b00000;
                end
            end
            LOCKED: begin
                if (w_edge) begin
                    if (w_period_band == r_band) begin
                        w_bp_n = r_bp;
                    end else begin
                        w_state_n = MEASURE;
                        w_bp_n    = 5'b00000;
                        w_band_n  = w_period_band;
                        if (w_period_band == BAND_NONE) begin
                            w_match_n = MC_ZERO;
                        end else begin
                            w_match_n = MC_ONE;
                        end
                    end
                end else if (w_timeout) begin
                    w_state_n = IDLE;
                    w_match_n = MC_ZERO;
                    w_band_n  = BAND_NONE;
                    w_bp_n    = 5'b00000;
                end else begin
                    w_bp_n = r_bp;
                end
            end
            default: begin
                w_state_n = IDLE;
                w_match_n = MC_ZERO;
                w_band_n  = BAND_NONE;
                w_bp_n    = 5'b00000;
            end
        endcase
    end

    // State, match tracking and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_band  <= BAND_NONE;
            r_match <= MC_ZERO;
            r_bp    <= 5'b00000;
            r_valid <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_band  <= w_band_n;
            r_match <= w_match_n;
            r_bp    <= w_bp_n;
            r_valid <= |w_bp_n;
        end
    end

    assign bp1       = r_bp[0];
    assign bp2       = r_bp[1];
    assign bp3       = r_bp[2];
    assign bp4       = r_bp[3];
    assign bp5       = r_bp[4];
    assign bandValid = r_valid;

endmodule

// File: tb/tb_tone_band_classifier.sv
// -----------------------------------------------------------------------------
// Directed bench for tone_band_classifier. Band windows and timeout are scaled
// by 1/100 so each scenario stays short; the relations between periods and
// windows match the full-size design.
//   band1 475..525 (tone 500)   band2 317..350 (tone 333)
//   band3 238..263 (tone 250)   band4 190..210 (tone 200)
//   band5 158..175 (tone 167)   timeout 1000, lock after 8 matching periods
// LAT is the number of cycles from raising toneIn to the clock edge that
// registers the resulting edge pulse (and so updates the outputs).
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_tone_band_classifier;

`ifdef TONE_GLITCH_FILTER_EN
    localparam int LAT = 7;
    localparam logic GLITCH_KEEPS_LOCK = 1'b1;
`else
    localparam int LAT = 3;
    localparam logic GLITCH_KEEPS_LOCK = 1'b0;
`endif
    localparam int TMO = 1000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       toneIn = 1'b0;
    logic       bp1, bp2, bp3, bp4, bp5, bandValid;
    logic [4:0] bp_vec;
    int         n_tests = 0;
    int         n_fail = 0;

    assign bp_vec = {bp5, bp4, bp3, bp2, bp1};

    tone_band_classifier #(
        .BAND1_LO(475), .BAND1_HI(525),
        .BAND2_LO(317), .BAND2_HI(350),
        .BAND3_LO(238), .BAND3_HI(263),
        .BAND4_LO(190), .BAND4_HI(210),
        .BAND5_LO(158), .BAND5_HI(175),
        .MATCH_COUNT(8),
        .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .toneIn(toneIn),
        .bp1(bp1), .bp2(bp2), .bp3(bp3), .bp4(bp4), .bp5(bp5),
        .bandValid(bandValid)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rise(input int wait_ticks);
        toneIn = 1'b1;
        repeat (wait_ticks) tick();
    endtask

    task automatic finish_period(input int period, input int elapsed);
        repeat (period / 2 - elapsed) tick();
        toneIn = 1'b0;
        repeat (period - period / 2) tick();
    endtask

    task automatic send(input int period, input int n);
        for (int i = 0; i < n; i++) begin
            rise(LAT);
            finish_period(period, LAT);
        end
    endtask

    task automatic do_reset();
        toneIn = 1'b0;
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        toneIn = 1'b0;
        repeat (2) tick();
        toneIn = 1'b1;
        repeat (8) tick();
        n_tests++;
        if (bp_vec !== 5'b00000 || bandValid !== 1'b0 || dut.r_state !== 2'b00) begin
            n_fail++;
            $display("FAIL reset_hold: bp=%b valid=%b state=%0d, required bp=00000 valid=0 state=0",
                     bp_vec, bandValid, dut.r_state);
        end
        toneIn = 1'b0;
        repeat (8) tick();
        rst = 1'b0;
        tick();
        n_tests++;
        if (bp_vec !== 5'b00000 || bandValid !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: bp=%b valid=%b, required 00000/0", bp_vec, bandValid);
        end
    endtask

    task automatic test_band1_lock();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            rise(LAT);
            n_tests++;
            if (bp_vec !== 5'b00000 || bandValid !== 1'b0) begin
                n_fail++;
                $display("FAIL band1_prelock edge %0d: bp=%b valid=%b, required 00000/0",
                         i, bp_vec, bandValid);
            end
            finish_period(500, LAT);
        end
        rise(LAT - 1);
        n_tests++;
        if (bp_vec !== 5'b00000) begin
            n_fail++;
            $display("FAIL band1_edge9_pulse_cycle: bp=%b, required 00000", bp_vec);
        end
        tick();
        n_tests++;
        if (bp_vec !== 5'b00001 || bandValid !== 1'b1) begin
            n_fail++;
            $display("FAIL band1_lock: bp=%b valid=%b, required 00001/1", bp_vec, bandValid);
        end
        finish_period(500, LAT);
        rise(LAT);
        n_tests++;
        if (bp_vec !== 5'b00001 || bandValid !== 1'b1) begin
            n_fail++;
            $display("FAIL band1_hold: bp=%b valid=%b, required 00001/1", bp_vec, bandValid);
        end
        finish_period(500, LAT);
    endtask

    task automatic test_band_switch();
        do_reset();
        send(250, 8);
        rise(LAT);
        n_tests++;
        if (bp_vec !== 5'b00100 || bandValid !== 1'b1) begin
            n_fail++;
            $display("FAIL switch_lock3: bp=%b valid=%b, required 00100/1", bp_vec, bandValid);
        end
        finish_period(250, LAT);
        rise(LAT);
        finish_period(167, LAT);
        rise(LAT - 1);
        n_tests++;
        if (bp_vec !== 5'b00100) begin
            n_fail++;
            $display("FAIL switch_bp3_before_drop: bp=%b, required 00100", bp_vec);
        end
        tick();
        n_tests++;
        if (bp_vec !== 5'b00000 || bandValid !== 1'b0) begin
            n_fail++;
            $display("FAIL switch_bp3_drop: bp=%b valid=%b, required 00000/0", bp_vec, bandValid);
        end
        finish_period(167, LAT);
        for (int i = 2; i <= 8; i++) begin
            rise(LAT);
            n_tests++;
            if (i < 8 && (bp_vec !== 5'b00000 || bandValid !== 1'b0)) begin
                n_fail++;
                $display("FAIL switch_prelock5 period %0d: bp=%b valid=%b, required 00000/0",
                         i, bp_vec, bandValid);
            end else if (i == 8 && (bp_vec !== 5'b10000 || bandValid !== 1'b1)) begin
                n_fail++;
                $display("FAIL switch_lock5: bp=%b valid=%b, required 10000/1", bp_vec, bandValid);
            end
            finish_period(167, LAT);
        end
    endtask

    task automatic test_between_bands();
        do_reset();
        for (int i = 1; i <= 21; i++) begin
            rise(LAT);
            n_tests++;
            if (bp_vec !== 5'b00000 || bandValid !== 1'b0) begin
                n_fail++;
                $display("FAIL between_bands edge %0d: bp=%b valid=%b, required 00000/0",
                         i, bp_vec, bandValid);
            end
            finish_period(400, LAT);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send(333, 8);
        rise(LAT);
        toneIn = 1'b0;
        n_tests++;
        if (bp_vec !== 5'b00010 || bandValid !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_lock2: bp=%b valid=%b, required 00010/1", bp_vec, bandValid);
        end
        repeat (TMO - 1) tick();
        n_tests++;
        if (bp_vec !== 5'b00010) begin
            n_fail++;
            $display("FAIL timeout_early: bp=%b one cycle before timeout, required 00010", bp_vec);
        end
        tick();
        n_tests++;
        if (bp_vec !== 5'b00000 || bandValid !== 1'b0 || dut.r_state !== 2'b00) begin
            n_fail++;
            $display("FAIL timeout_drop: bp=%b valid=%b state=%0d, required 00000/0 state=0",
                     bp_vec, bandValid, dut.r_state);
        end
    endtask

    task automatic test_reset_mid_lock();
        do_reset();
        send(200, 8);
        rise(LAT);
        n_tests++;
        if (bp_vec !== 5'b01000 || bandValid !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_lock4: bp=%b valid=%b, required 01000/1", bp_vec, bandValid);
        end
        repeat (100 - LAT) tick();
        toneIn = 1'b0;
        repeat (20) tick();
        rst = 1'b1;
        tick();
        n_tests++;
        if (bp_vec !== 5'b00000 || bandValid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_clear: bp=%b valid=%b, required 00000/0", bp_vec, bandValid);
        end
        rst = 1'b0;
        repeat (20) tick();
        for (int i = 1; i <= 9; i++) begin
            rise(LAT);
            n_tests++;
            if (i < 9 && bp_vec !== 5'b00000) begin
                n_fail++;
                $display("FAIL midreset_early_relock edge %0d: bp=%b, required 00000", i, bp_vec);
            end else if (i == 9 && (bp_vec !== 5'b01000 || bandValid !== 1'b1)) begin
                n_fail++;
                $display("FAIL midreset_relock: bp=%b valid=%b, required 01000/1", bp_vec, bandValid);
            end
            finish_period(200, LAT);
        end
    endtask

    task automatic test_window_edges();
        do_reset();
        for (int i = 1; i <= 8; i++) begin
            rise(LAT);
            finish_period((i % 2 == 1) ? 190 : 210, LAT);
        end
        rise(LAT);
        n_tests++;
        if (bp_vec !== 5'b01000 || bandValid !== 1'b1) begin
            n_fail++;
            $display("FAIL window_inclusive_lock: bp=%b valid=%b, required 01000/1", bp_vec, bandValid);
        end
        finish_period(189, LAT);
        rise(LAT);
        n_tests++;
        if (bp_vec !== 5'b00000 || bandValid !== 1'b0) begin
            n_fail++;
            $display("FAIL window_below_lo: bp=%b valid=%b, required 00000/0", bp_vec, bandValid);
        end
        finish_period(200, LAT);
    endtask

    task automatic test_timeout_tie();
        do_reset();
        send(200, 8);
        rise(LAT);
        n_tests++;
        if (bp_vec !== 5'b01000) begin
            n_fail++;
            $display("FAIL tie_lock4: bp=%b, required 01000", bp_vec);
        end
        finish_period(TMO, LAT);
        rise(LAT - 1);
        n_tests++;
        if (bp_vec !== 5'b01000) begin
            n_fail++;
            $display("FAIL tie_before: bp=%b, required 01000", bp_vec);
        end
        tick();
        n_tests++;
        if (bp_vec !== 5'b00000 || bandValid !== 1'b0 || dut.r_state !== 2'b01) begin
            n_fail++;
            $display("FAIL tie_edge_wins: bp=%b valid=%b state=%0d, required 00000/0 state=1",
                     bp_vec, bandValid, dut.r_state);
        end
        finish_period(200, LAT);
    endtask

    task automatic test_glitch();
        logic [4:0] exp_bp;
        exp_bp = GLITCH_KEEPS_LOCK ? 5'b00001 : 5'b00000;
        do_reset();
        send(500, 8);
        rise(LAT);
        n_tests++;
        if (bp_vec !== 5'b00001) begin
            n_fail++;
            $display("FAIL glitch_lock1: bp=%b, required 00001", bp_vec);
        end
        for (int g = 0; g < 2; g++) begin
            repeat (250 - LAT) tick();
            toneIn = 1'b0;
            repeat (120) tick();
            toneIn = 1'b1;
            repeat (2) tick();
            toneIn = 1'b0;
            repeat (128) tick();
            rise(LAT);
            n_tests++;
            if (bp_vec !== exp_bp || bandValid !== exp_bp[0]) begin
                n_fail++;
                $display("FAIL glitch_period %0d: bp=%b valid=%b, required %b/%b",
                         g, bp_vec, bandValid, exp_bp, exp_bp[0]);
            end
        end
        finish_period(500, LAT);
    endtask

    initial begin
        test_reset();
        test_band1_lock();
        test_band_switch();
        test_between_bands();
        test_timeout();
        test_reset_mid_lock();
        test_window_edges();
        test_timeout_tie();
        test_glitch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
